// File: rtl/bstep_rr_scheduler.sv
// bstep_rr_scheduler: shares one binary-step activation evaluator between
// NREQ requesters. A batch is launched by Start with a result count; requesters
// are granted round-robin, each accepted sample is reduced to a 1-bit step
// result, and the result is held in a single registered output slot tagged
// with its source ID. Done pulses once the final result of the batch has been
// consumed downstream.
module bstep_rr_scheduler #(
   parameter int                       NREQ   = 4,
   parameter int                       WIDTH  = 6,
   parameter logic signed [WIDTH-1:0]  THRESH = '0,
   parameter int                       LENW   = 8,
   parameter int                       IDW    = $clog2(NREQ)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   input  logic [LENW-1:0]         Batch_Len,
   output logic                    Busy,
   output logic                    Done,
   input  logic [NREQ-1:0]         Req_Valid,
   input  logic [NREQ*WIDTH-1:0]   Req_Data,
   output logic [NREQ-1:0]         Req_Ready,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic                    Out1,
   output logic [IDW-1:0]          Out_Id,
   output logic                    Out_Last
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [LENW-1:0]   remaining_q, remaining_d;
   logic              out_valid_q, out_valid_d;
   logic              out1_q, out1_d;
   logic [IDW-1:0]    out_id_q, out_id_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;

   logic              found;
   logic [IDW-1:0]    gnt_idx;
   logic              slot_free;
   logic              accept;
   logic [WIDTH-1:0]  gnt_data;
   logic              step_bit;

   // Round-robin search: first valid requester at or after ptr, wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && Req_Valid[(int'(ptr_q) + k) % NREQ]) begin
            found   = 1'b1;
            gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // Grant decision, one-hot ready and step evaluation of the granted sample.
   always_comb begin
      slot_free = !out_valid_q || Out_Ready;
      accept    = (state_q == ST_RUN) && slot_free && found &&
                  (remaining_q != '0);
      Req_Ready = '0;
      if (accept) begin
         Req_Ready[gnt_idx] = 1'b1;
      end
      gnt_data = Req_Data[int'(gnt_idx)*WIDTH +: WIDTH];
      step_bit = ($signed(gnt_data) >= $signed(THRESH));
   end

   // Next-state logic for the batch FSM and the single result slot.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out1_d      = out1_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      // Result consumed downstream; a new accept below may refill the slot.
      if (out_valid_q && Out_Ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (Batch_Len != '0) begin
                  state_d     = ST_RUN;
                  remaining_d = Batch_Len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out1_d      = step_bit;
               out_id_d    = gnt_idx;
               out_last_d  = (remaining_q == LENW'(1));
               ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LENW'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The held result here is always the batch's last one.
            if (out_valid_q && Out_Ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset; Rst overrides any Start.
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (Rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out1_q      <= 1'b0;
         out_id_q    <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out1_q      <= out1_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign Busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign Done      = done_q;
   assign Out_Valid = out_valid_q;
   assign Out1      = out1_q;
   assign Out_Id    = out_id_q;
   assign Out_Last  = out_last_q;

endmodule

// File: tb/tb_bstep_rr_scheduler.sv
// Testbench for bstep_rr_scheduler (default parameters: 4 requesters,
// 6-bit samples, threshold 0). Directed vector table, hand-written sequences
// for reset and round-robin order, then randomized traffic against a
// cycle-level reference model.
module tb_bstep_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;
   localparam int LENW  = 8;
   localparam int IDW   = 2;

   logic                  Clk = 1'b0;
   logic                  Rst;
   logic                  Start;
   logic [LENW-1:0]       Batch_Len;
   logic                  Busy;
   logic                  Done;
   logic [NREQ-1:0]       Req_Valid;
   logic [NREQ*WIDTH-1:0] Req_Data;
   logic [NREQ-1:0]       Req_Ready;
   logic                  Out_Valid;
   logic                  Out_Ready;
   logic                  Out1;
   logic [IDW-1:0]        Out_Id;
   logic                  Out_Last;

   int checks   = 0;
   int failures = 0;

   bstep_rr_scheduler dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Batch_Len (Batch_Len),
      .Busy      (Busy),
      .Done      (Done),
      .Req_Valid (Req_Valid),
      .Req_Data  (Req_Data),
      .Req_Ready (Req_Ready),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out1      (Out1),
      .Out_Id    (Out_Id),
      .Out_Last  (Out_Last)
   );

   always #5 Clk = ~Clk;

   // Observed output bundle: {Req_Ready, Out_Valid, Out1, Out_Id, Out_Last, Done, Busy}
   typedef struct {
      logic            start;
      logic [7:0]      len;
      logic [3:0]      vld;
      logic [23:0]     data;
      logic            ordy;
      logic [10:0]     exp;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Payload fields only matter while a result is being presented.
   function automatic logic [10:0] obs(input logic pay);
      return {Req_Ready, Out_Valid, pay ? Out1 : 1'b0, pay ? Out_Id : 2'b00,
              pay ? Out_Last : 1'b0, Done, Busy};
   endfunction

   function automatic logic [23:0] d(input int slot, input logic [5:0] val);
      return 24'(val) << (slot * WIDTH);
   endfunction

   function automatic vec_t mk(input logic st, input logic [7:0] ln, input logic [3:0] vl,
                               input logic [23:0] dt, input logic ordy, input logic [3:0] rdy,
                               input logic ov, input logic o1, input logic [1:0] id,
                               input logic last, input logic done, input logic busy);
      vec_t v;
      v.start = st;
      v.len   = ln;
      v.vld   = vl;
      v.data  = dt;
      v.ordy  = ordy;
      v.exp   = {rdy, ov, ov ? o1 : 1'b0, ov ? id : 2'b00, ov ? last : 1'b0, done, busy};
      return v;
   endfunction

   // ---------------- reference model (random phase) ----------------
   typedef enum int {M_IDLE, M_RUN, M_DRAIN} mode_t;
   mode_t      m_mode;
   int         m_ptr, m_rem;
   logic       m_hold, m_o1, m_last, m_done;
   int         m_id;

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic step_of(input logic [5:0] s);
      return $signed(s) >= 0;
   endfunction

   logic [23:0] bp_data;
   int          lens[$];
   int          cyc;
   int          g;
   logic [3:0]  e_rdy;
   logic [10:0] e_vec;
   logic        nd;

   initial begin
      Rst = 1'b1; Start = 1'b0; Batch_Len = '0; Req_Valid = '0; Req_Data = '0; Out_Ready = 1'b1;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      #1 check("reset_state", 32'(obs(1'b1)), 32'(11'b0));

      // ---- directed table ----
      // Basic batch of 3 through req0 (ptr 0 -> 1)
      tbl.push_back(mk(1, 3, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 4'h1, d(0, 6'h05), 1, 4'h1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h1, d(0, 6'h20), 1, 4'h1, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h1, d(0, 6'h1F), 1, 4'h1, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h1, d(0, 6'h05), 1, 4'h0, 1, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 0, 0));
      // Boundary samples through req2 (ptr 1 -> 3)
      tbl.push_back(mk(1, 4, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 4'h4, d(2, 6'h00), 1, 4'h4, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h4, d(2, 6'h1F), 1, 4'h4, 1, 1, 2, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h4, d(2, 6'h3F), 1, 4'h4, 1, 1, 2, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h4, d(2, 6'h20), 1, 4'h4, 1, 0, 2, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h4, d(2, 6'h00), 1, 4'h0, 1, 0, 2, 1, 0, 1));
      tbl.push_back(mk(0, 0, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 1, 0));
      // Backpressure, all valid (ptr 3 -> 2)
      bp_data = d(0, 6'h05) | d(1, 6'h3F) | d(2, 6'h10) | d(3, 6'h20);
      tbl.push_back(mk(1, 3, 4'h0, 24'h0,   1, 4'h0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h8, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 0, 4'h0, 1, 0, 3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 0, 4'h0, 1, 0, 3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 0, 4'h0, 1, 0, 3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h1, 1, 0, 3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h2, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 0, 4'h0, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h0, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 4'h0, 24'h0,   1, 4'h0, 0, 0, 0, 0, 1, 0));
      // Zero-length batch
      tbl.push_back(mk(1, 0, 4'h0, 24'h0,   1, 4'h0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 4'hF, bp_data, 1, 4'h0, 0, 0, 0, 0, 0, 0));
      // Start during RUN is ignored (ptr 2 -> 1)
      tbl.push_back(mk(1, 2, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 4'h1, d(0, 6'h05), 1, 4'h1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 7, 4'h1, d(0, 6'h05), 1, 4'h1, 1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 4'h1, d(0, 6'h05), 1, 4'h0, 1, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 4'h0, 24'h0,       1, 4'h0, 0, 0, 0, 0, 1, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge Clk);
         Start = tbl[i].start; Batch_Len = tbl[i].len; Req_Valid = tbl[i].vld;
         Req_Data = tbl[i].data; Out_Ready = tbl[i].ordy;
         #1 check($sformatf("vec%0d", i), 32'(obs(tbl[i].exp[6])), 32'(tbl[i].exp));
      end

      // ---- reset mid-batch, Start+Rst together ----
      @(negedge Clk);
      Start = 1'b1; Batch_Len = 8'd8; Req_Valid = '0; Out_Ready = 1'b1;
      @(negedge Clk);
      Start = 1'b0; Req_Valid = 4'hF; Req_Data = 24'($urandom);
      @(negedge Clk);
      #1 check("ov_before_rst", 32'(Out_Valid), 32'(1));
      Rst = 1'b1; Start = 1'b1; Batch_Len = 8'd5;
      @(negedge Clk);
      Rst = 1'b0; Start = 1'b0;
      #1 check("after_rst", 32'({Req_Ready, Out_Valid, Busy, Done}), 32'(0));

      // ---- round robin from ptr 0, all valid, 8 results ----
      Start = 1'b1; Batch_Len = 8'd8;
      for (int k = 0; k <= 8; k++) begin
         @(negedge Clk);
         Start = 1'b0; Req_Data = 24'($urandom);
         #1;
         check($sformatf("rr_ready%0d", k), 32'(Req_Ready), (k < 8) ? 32'(1 << (k % 4)) : 32'(0));
         if (k > 0) begin
            check($sformatf("rr_out%0d", k), 32'({Out_Valid, Out_Id, Out_Last, Done}),
                  32'({1'b1, 2'((k - 1) % 4), (k == 8), 1'b0}));
         end
      end
      @(negedge Clk);
      #1 check("rr_done", 32'({Done, Busy, Out_Valid}), 32'(3'b100));
      @(negedge Clk);
      #1 check("rr_done_once", 32'({Done, Busy}), 32'(0));

      // ---- randomized traffic vs reference model ----
      m_mode = M_IDLE; m_ptr = 0; m_rem = 0; m_hold = 0; m_o1 = 0; m_last = 0; m_done = 0; m_id = 0;
      lens = '{1, 2, 5, 0, 3, 255, 4, 1, 7, 0, 2};
      cyc = 0;
      while ((lens.size() > 0 || m_mode != M_IDLE) && cyc < 20000) begin
         @(negedge Clk);
         cyc++;
         Start = 1'b0;
         if (m_mode == M_IDLE && lens.size() > 0 && ($urandom % 3 == 0)) begin
            Start = 1'b1; Batch_Len = 8'(lens.pop_front());
         end else if (m_mode != M_IDLE && ($urandom % 16 == 0)) begin
            Start = 1'b1; Batch_Len = 8'($urandom);
         end
         Req_Valid = 4'($urandom);
         Req_Data  = 24'($urandom);
         Out_Ready = ($urandom % 4) != 0;
         #1;
         g = rr_pick(Req_Valid, m_ptr);
         e_rdy = '0;
         if (m_mode == M_RUN && (!m_hold || Out_Ready) && g >= 0) e_rdy[g] = 1'b1;
         e_vec = {e_rdy, m_hold, m_hold ? m_o1 : 1'b0, m_hold ? 2'(m_id) : 2'b00,
                  m_hold ? m_last : 1'b0, m_done, m_mode != M_IDLE};
         check($sformatf("rand_cyc%0d", cyc), 32'(obs(m_hold)), 32'(e_vec));
         // advance model to the next cycle
         nd = 1'b0;
         case (m_mode)
            M_IDLE: if (Start) begin
               if (Batch_Len != 0) begin m_mode = M_RUN; m_rem = int'(Batch_Len); end
               else nd = 1'b1;
            end
            M_RUN: if (e_rdy != 0) begin
               m_hold = 1'b1;
               m_o1   = step_of(Req_Data[g*WIDTH +: WIDTH]);
               m_id   = g;
               m_last = (m_rem == 1);
               m_ptr  = (g + 1) % NREQ;
               m_rem  = m_rem - 1;
               if (m_rem == 0) m_mode = M_DRAIN;
            end else if (m_hold && Out_Ready) begin
               m_hold = 1'b0;
            end
            default: if (m_hold && Out_Ready) begin
               m_hold = 1'b0; m_mode = M_IDLE; nd = 1'b1;
            end
         endcase
         m_done = nd;
      end
      check("rand_no_timeout", 32'(cyc < 20000), 32'(1));
      @(negedge Clk);
      Start = 1'b0;
      #1 check("rand_final_done", 32'({Done, Busy}), 32'({m_done, 1'b0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bstep_rr_scheduler.md
# bstep_rr_scheduler

Round-robin scheduler that shares one binary-step activation evaluator between NREQ requesters. It runs in batches: Start loads a result count, and the block grants requesters fairly, evaluates one WIDTH-bit signed sample per accepted request, and emits one registered 1-bit result with requester ID. After the last result is consumed it pulses Done. It sits between the neuron accumulators and the downstream spike/bit packer in the activation-function datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 6, sample width, two's-complement signed
- THRESH, 0, signed step threshold (WIDTH bits)
- LENW, 8, batch-length counter width
- IDW, $clog2(NREQ), ID width

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  batch start pulse
- Batch_Len  in  LENW  results in batch, sampled with Start
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  one-cycle pulse at batch end
- Req_Valid  in  NREQ  per-requester valid
- Req_Data  in  NREQ*WIDTH  requester i sample at [i*WIDTH +: WIDTH]
- Req_Ready  out  NREQ  one-hot (or zero) grant/accept
- Out_Valid  out  1  result valid
- Out_Ready  in  1  downstream accept
- Out1  out  1  step result
- Out_Id  out  IDW  source requester of Out1
- Out_Last  out  1  marks final result of batch

## Operation
- Step function: Out1 = 1 iff $signed(data) >= $signed(THRESH). With THRESH=0 this is ~data[WIDTH-1].
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - Req_Ready=0.
  - Start with Batch_Len≠0 → RUN, with remaining=Batch_Len.
  - Start with Batch_Len=0 → Done pulse next cycle, stay IDLE.
- Start outside IDLE is ignored.
- RUN:
  - slot_free = !Out_Valid | Out_Ready.
  - g = first i with Req_Valid[i], searching cyclically from ptr.
  - Req_Ready[g]=1 iff slot_free and some Req_Valid is set; all other bits are 0. Req_Ready may depend combinationally on Req_Valid.
- Accept = Req_Valid[g] & Req_Ready[g]. On accept:
  - Out1 ← step(data_g), Out_Id ← g, Out_Last ← (remaining==1), Out_Valid ← 1.
  - ptr ← (g+1) mod NREQ; remaining ← remaining−1.
  - If remaining was 1 → DRAIN.
- Without accept, if Out_Valid & Out_Ready → Out_Valid ← 0.
- DRAIN:
  - No grants.
  - When the Out_Last result handshakes (Out_Valid & Out_Ready): IDLE next cycle, Out_Valid ← 0, and Done is high in that first IDLE cycle.
- While Out_Valid=1 and Out_Ready=0, Out1/Out_Id/Out_Last hold stable.
- The ptr is not reset between batches; only Rst clears it.

## Timing
- Reset values (cycle after Rst high): state IDLE, ptr 0, remaining 0, Out_Valid 0, Out1 0, Out_Id 0, Out_Last 0, Done 0, Busy 0.
- Rst mid-batch discards any held result and the remaining count.
- Latency: accept in cycle n → Out_Valid in n+1.
- Throughput: 1 result/cycle while Out_Ready=1 (simultaneous drain and accept allowed).
- Busy rises the cycle after the accepted Start and falls in the Done cycle.
- Done lasts 1 cycle. A Start in the Done cycle is accepted (state is IDLE).
- Start and Rst in the same cycle: Rst wins.
- Batch_Len = 2^LENW−1 must complete without wrap. remaining never underflows; no grants at 0.

## Test plan
- Reset; Start, Batch_Len=3; only req0 valid with data 6'h05, 6'h20, 6'h1F; Out_Ready=1 → Out1 = 1,0,1, Out_Id=0 each, Out_Last on 3rd only, Done exactly one cycle after the 3rd handshake, Busy low that cycle.
- All 4 requesters continuously valid, Batch_Len=8, Out_Ready=1 → Out_Id = 0,1,2,3,0,1,2,3 on consecutive cycles; 8 results; Done once.
- Backpressure: Out_Ready=0 for 3 cycles while Out_Valid=1 → Out1/Out_Id stable, Req_Ready=0, no sample lost; order resumes on Out_Ready=1.
- Boundary data via req2, THRESH=0 → 6'h00→1, 6'h1F→1, 6'h3F(−1)→0, 6'h20(−32)→0; Out_Id=2.
- Start with Batch_Len=0 → Done next cycle, Busy never high, no Req_Ready. Start during RUN → ignored, batch count unchanged.
- Rst asserted in RUN with Out_Valid=1 → next cycle Out_Valid=0, Busy=0, Done=0. New batch with all requesters valid grants req0 first.
